// File: rtl/crc16_rx_pkg.sv
// Shared definitions for the receive-side CRC-16 frame checker:
// FSM state encoding, polynomial-select encoding and CRC width.
package crc16_rx_pkg;

  localparam int CRC_W = 16;

  localparam logic POLY_1021 = 1'b0;
  localparam logic POLY_8005 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    STATUS = 3'd4
  } state_t;

endpackage

// File: rtl/crc16_1021.sv
// One-byte step of the MSB-first (left-shifting) CRC-16 with polynomial 0x1021.
// Ports:
//   crc_i  : current CRC value
//   data_i : input byte, consumed MSB first
//   crc_o  : CRC value after absorbing data_i
module crc16_1021
  import crc16_rx_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_i ^ {data_i, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_8005.sv
// One-byte step of the MSB-first (left-shifting) CRC-16 with polynomial 0x8005.
// Ports:
//   crc_i  : current CRC value
//   data_i : input byte, consumed MSB first
//   crc_o  : CRC value after absorbing data_i
module crc16_8005
  import crc16_rx_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_i ^ {data_i, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_rx_checker.sv
// Receive-side CRC-16 frame checker. Input frames end with a big-endian
// CRC-16; the checker forwards the payload with the two CRC bytes stripped,
// accumulates the CRC over the payload and emits one status pulse per frame.
// Ports:
//   clk_i, rst_n_i           : clock, synchronous active-low reset
//   poly_sel_i, init_i,
//   xorout_i                 : per-frame config, taken with the first byte
//   s_valid_i/s_ready_o,
//   s_data_i, s_last_i       : input byte stream (s_last_i on CRC low byte)
//   m_valid_o/m_ready_i,
//   m_data_o, m_last_o       : payload byte stream
//   sts_valid_o, sts_ok_o,
//   sts_short_o              : one-cycle per-frame status
module crc16_rx_checker
  import crc16_rx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             poly_sel_i,
  input  logic [CRC_W-1:0] init_i,
  input  logic [CRC_W-1:0] xorout_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             sts_valid_o,
  output logic             sts_ok_o,
  output logic             sts_short_o
);

  state_t           state_q, state_d;
  logic [7:0]       h1_q, h0_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] xorout_q;
  logic             poly_q;
  logic             ok_q, short_q;
  logic [CRC_W-1:0] step_1021, step_8005, crc_step;
  logic             s_acc, m_acc;

  crc16_1021 u_crc16_1021 (.crc_i(crc_q), .data_i(h1_q), .crc_o(step_1021));
  crc16_8005 u_crc16_8005 (.crc_i(crc_q), .data_i(h1_q), .crc_o(step_8005));

  assign crc_step = (poly_q == POLY_8005) ? step_8005 : step_1021;

  // In STREAM a new byte pushes h1 into the output register, so input is
  // only taken when that register is free or being emptied this cycle.
  assign s_ready_o = (state_q == IDLE) || (state_q == FILL) ||
                     ((state_q == STREAM) && (!m_valid_o || m_ready_i));
  assign s_acc = s_valid_i && s_ready_o;
  assign m_acc = m_valid_o && m_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sts_valid_o = 1'b0;
    sts_ok_o    = 1'b0;
    sts_short_o = 1'b0;
    case (state_q)
      IDLE:   if (s_acc) state_d = s_last_i ? STATUS : FILL;
      FILL:   if (s_acc) state_d = s_last_i ? STATUS : STREAM;
      STREAM: if (s_acc && s_last_i) state_d = DRAIN;
      // The only byte left in the output register in DRAIN carries m_last_o.
      DRAIN:  if (m_acc) state_d = STATUS;
      STATUS: begin
        state_d     = IDLE;
        sts_valid_o = 1'b1;
        sts_ok_o    = ok_q;
        sts_short_o = short_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding line: data only, its occupancy is tracked by the FSM state.
  always_ff @(posedge clk_i) begin
    if (s_acc) begin
      h1_q <= h0_q;
      h0_q <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= 8'h00;
      crc_q     <= '0;
      xorout_q  <= '0;
      poly_q    <= POLY_1021;
      ok_q      <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_acc) begin
          poly_q   <= poly_sel_i;
          xorout_q <= xorout_i;
          crc_q    <= init_i;
          ok_q     <= 1'b0;
          short_q  <= s_last_i;
        end
        // Empty payload: the received CRC must equal init ^ xorout.
        FILL: if (s_acc && s_last_i) begin
          ok_q <= ({h0_q, s_data_i} == (crc_q ^ xorout_q));
        end
        STREAM: begin
          if (s_acc) begin
            m_data_o  <= h1_q;
            m_valid_o <= 1'b1;
            crc_q     <= crc_step;
            if (s_last_i) begin
              m_last_o <= 1'b1;
              ok_q     <= ({h0_q, s_data_i} == (crc_step ^ xorout_q));
            end
          end else if (m_acc) begin
            m_valid_o <= 1'b0;
          end
        end
        DRAIN: if (m_acc) begin
          m_valid_o <= 1'b0;
          m_last_o  <= 1'b0;
        end
        STATUS: crc_q <= init_i;
        default: ;
      endcase
    end
  end

endmodule
